regfile_sb: RTL
===============

Name: regfile_sb

Overview:
Parametrised multi-port register file for the datapath. It has one write port, two independent read ports, and a per-register busy scoreboard. The scoreboard lets the controller reserve a destination register and stall readers until the pending write lands. It replaces the single-read-port, fixed 8x16 file, and adds reset, optional write-through bypass, registered-read mode and an optional hardwired-zero R0.

Parameters:
WIDTH, 16, data width of every register and data port
ADDR_W, 3, register index width; register count NREGS = 2**ADDR_W (derived, not overridable)
READ_REG, 0, 0 = combinational read (0 latency); 1 = registered read outputs (1-cycle latency)
BYPASS, 1, 1 = same-cycle write data and busy-clear are forwarded to read ports; 0 = no forwarding
ZERO_R0, 0, 1 = register 0 reads as 0, ignores writes, never becomes busy

Ports:
clk  in  1  rising-edge clock
rst_n  in  1  asynchronous active-low reset
data_in  in  WIDTH  write data
writenum  in  ADDR_W  write index
write  in  1  write enable
readnum_a  in  ADDR_W  read port A index
readnum_b  in  ADDR_W  read port B index
data_out_a  out  WIDTH  read port A data
data_out_b  out  WIDTH  read port B data
busy_a  out  1  register selected on port A has a pending write
busy_b  out  1  register selected on port B has a pending write
reserve  in  1  request to mark reservenum busy
reservenum  in  ADDR_W  index to reserve
reserve_ack  out  1  reservation accepted this cycle (combinational)
busy_vec  out  NREGS  full scoreboard, bit i = register i busy

Behaviour:
- Reset (rst_n low, asynchronous): all registers = 0, all busy bits = 0, busy_vec = 0, reserve_ack = 0 while reset is asserted. In READ_REG=1 mode the data_out and busy output flops = 0. Reset asserted mid-reservation discards all pending busy state.
- Write: at posedge clk with write=1, reg[writenum] <= data_in and busy[writenum] <= 0. Writing a register that is not busy is legal; the data is updated.
- Reserve: reserve_ack = reserve & ~busy[reservenum] (evaluated before any same-cycle write clear, i.e. no bypass on ack). On ack, busy[reservenum] <= 1 at the posedge. A reserve of an already-busy register gives ack=0 and no state change; the requester retries.
- Simultaneous write and reserve to the same index: the data is written and busy ends at 1, because the reservation wins. Only possible with ack=1, i.e. when the register was not busy.
- Simultaneous write and reserve to different indices: both take effect independently.
- Combinational read (READ_REG=0): data_out_x = reg[readnum_x]; busy_x = busy[readnum_x].
  - With BYPASS=1 and write=1 and writenum==readnum_x: data_out_x = data_in and busy_x = 0.
  - Both ports may address the same register.
- Registered read (READ_REG=1): at each posedge, data_out_x and busy_x capture the values the combinational path would produce in that cycle, so they appear 1 cycle after readnum_x is presented. Bypass applies to the captured value.
- ZERO_R0=1: writes to index 0 are dropped; reads of index 0 return 0 with busy 0. reserve of index 0 gives ack=1 but busy[0] stays 0 (busy_vec[0] always 0).
- busy_vec reflects registered scoreboard state only; no bypass.
- No index range checks are needed: every ADDR_W value is a valid register.

Test Plan:
- Reset then read: rst_n=0 for 2 cycles, release, readnum_a=5, readnum_b=7 -> data_out_a=data_out_b=0, busy_vec=8'h00.
- Write/read two ports (WIDTH=16, READ_REG=0): write R3=16'hBEEF, R6=16'h1234 on consecutive cycles; then readnum_a=3, readnum_b=6 -> 16'hBEEF / 16'h1234 same cycle. With READ_REG=1 the same values appear one cycle later.
- Bypass: R2 holds 16'h0001; same cycle write=1, writenum=2, data_in=16'hA5A5, readnum_a=2 -> data_out_a=16'hA5A5 with BYPASS=1; 16'h0001 with BYPASS=0.
- Scoreboard:
  - reserve R4 -> ack=1, next cycle busy_vec[4]=1 and busy_a=1 (readnum_a=4).
  - Second reserve R4 -> ack=0.
  - write R4=16'h00FF -> busy_vec[4]=0 next cycle; with BYPASS=1, busy_a=0 in the write cycle.
- Write+reserve same index: R1 idle; write=1, reserve=1, both index 1, data_in=16'h7777 -> ack=1; next cycle reg1=16'h7777 and busy_vec[1]=1.
- Async reset mid-operation: R4 busy holding 16'h00FF; drop rst_n between clock edges -> busy_vec=0 and data_out_a=0 immediately, without waiting for a clock edge. With ZERO_R0=1, write R0=16'hFFFF -> reads 0, reserve R0 ack=1, busy_vec[0]=0.

Source files
------------

// File: rtl/regfile_sb.sv
// Register file with one write port, two read ports and a per-register busy
// scoreboard used to reserve a destination until its pending write lands.
module regfile_sb #(
  parameter int WIDTH    = 16,
  parameter int ADDR_W   = 3,
  parameter int READ_REG = 0,
  parameter int BYPASS   = 1,
  parameter int ZERO_R0  = 0
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [WIDTH-1:0]     data_in,
  input  logic [ADDR_W-1:0]    writenum,
  input  logic                 write,
  input  logic [ADDR_W-1:0]    readnum_a,
  input  logic [ADDR_W-1:0]    readnum_b,
  output logic [WIDTH-1:0]     data_out_a,
  output logic [WIDTH-1:0]     data_out_b,
  output logic                 busy_a,
  output logic                 busy_b,
  input  logic                 reserve,
  input  logic [ADDR_W-1:0]    reservenum,
  output logic                 reserve_ack,
  output logic [2**ADDR_W-1:0] busy_vec
);

  localparam int NREGS = 2**ADDR_W;

  logic [WIDTH-1:0] regs_q [NREGS];
  logic [WIDTH-1:0] regs_d [NREGS];
  logic [NREGS-1:0] busy_q;
  logic [NREGS-1:0] busy_d;
  logic             write_eff;
  logic [WIDTH-1:0] data_a_d;
  logic [WIDTH-1:0] data_b_d;
  logic             busy_a_d;
  logic             busy_b_d;

  // Ack looks only at registered busy state; the reservation is applied after
  // the write clear so a same-index write+reserve leaves the register busy.
  always_comb begin
    write_eff   = write && !(ZERO_R0 != 0 && writenum == '0);
    reserve_ack = rst_n && reserve && !busy_q[reservenum];
    regs_d      = regs_q;
    busy_d      = busy_q;
    if (write_eff) begin
      regs_d[writenum] = data_in;
      busy_d[writenum] = 1'b0;
    end
    if (reserve_ack && !(ZERO_R0 != 0 && reservenum == '0)) begin
      busy_d[reservenum] = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      regs_q <= '{default: '0};
      busy_q <= '0;
    end else begin
      regs_q <= regs_d;
      busy_q <= busy_d;
    end
  end

  always_comb begin
    data_a_d = regs_q[readnum_a];
    busy_a_d = busy_q[readnum_a];
    data_b_d = regs_q[readnum_b];
    busy_b_d = busy_q[readnum_b];
    if (BYPASS != 0 && write_eff && writenum == readnum_a) begin
      data_a_d = data_in;
      busy_a_d = 1'b0;
    end
    if (BYPASS != 0 && write_eff && writenum == readnum_b) begin
      data_b_d = data_in;
      busy_b_d = 1'b0;
    end
    // R0 is forced at the read mux so it reads as a constant in every mode.
    if (ZERO_R0 != 0 && readnum_a == '0) begin
      data_a_d = '0;
      busy_a_d = 1'b0;
    end
    if (ZERO_R0 != 0 && readnum_b == '0) begin
      data_b_d = '0;
      busy_b_d = 1'b0;
    end
  end

  if (READ_REG != 0) begin : g_rd_reg
    logic [WIDTH-1:0] data_a_q;
    logic [WIDTH-1:0] data_b_q;
    logic             busy_a_q;
    logic             busy_b_q;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        data_a_q <= '0;
        data_b_q <= '0;
        busy_a_q <= 1'b0;
        busy_b_q <= 1'b0;
      end else begin
        data_a_q <= data_a_d;
        data_b_q <= data_b_d;
        busy_a_q <= busy_a_d;
        busy_b_q <= busy_b_d;
      end
    end

    assign data_out_a = data_a_q;
    assign data_out_b = data_b_q;
    assign busy_a     = busy_a_q;
    assign busy_b     = busy_b_q;
  end else begin : g_rd_comb
    assign data_out_a = data_a_d;
    assign data_out_b = data_b_d;
    assign busy_a     = busy_a_d;
    assign busy_b     = busy_b_d;
  end

  assign busy_vec = busy_q;

endmodule
